// File: rtl/nn_pkg.sv
// Shared types and constants for the nn_ram front-end blocks.
//   nn_ram_ctrl_state_t : controller FSM states
//   nn_grant_t          : which requester owned the RAM port last
//   NN_RD_LAT_MAX       : largest RAM read latency the controller supports
package nn_pkg;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN} nn_ram_ctrl_state_t;

  typedef enum logic {GRANT_WR, GRANT_RD} nn_grant_t;

  localparam int NN_RD_LAT_MAX = 3;

endpackage

// File: rtl/nn_valid_pipe.sv
// Delay line for the {valid, last} tag that follows each issued read address,
// matching the RAM read latency.
//   clk_i   : clock
//   clr_i   : synchronous clear, empties every stage
//   valid_i : an address is presented to the RAM this cycle
//   last_i  : that address is the final one of the burst
//   valid_o : tag delayed by Depth cycles
//   last_o  : last flag delayed by Depth cycles, only ever high with valid_o
// Depth = 0 makes the block a pass-through.
module nn_valid_pipe #(
  parameter int unsigned Depth = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  if (Depth == 0) begin : g_pass
    assign valid_o = valid_i;
    assign last_o  = last_i & valid_i;
  end else begin : g_pipe
    logic [Depth-1:0] valid_q, valid_d;
    logic [Depth-1:0] last_q, last_d;

    always_comb begin
      valid_d    = valid_q;
      last_d     = last_q;
      valid_d[0] = valid_i;
      last_d[0]  = last_i & valid_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        valid_d[i] = valid_q[i-1];
        last_d[i]  = last_q[i-1];
      end
      if (clr_i) begin
        valid_d = '0;
        last_d  = '0;
      end
    end

    always_ff @(posedge clk_i) begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end

    assign valid_o = valid_q[Depth-1];
    assign last_o  = last_q[Depth-1];
  end

endmodule

// File: rtl/nn_ram_ctrl.sv
// Arbiter and burst sequencer in front of one nn_ram block.
//   Clk, Rst                        : clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data : single-word write requester
//   rd_valid_req/rd_ready_req/rd_base/rd_len : burst read requester
//   rd_busy                         : a burst is in flight
//   rd_data/rd_dvalid/rd_last       : returned burst words with framing
//   ram_addr/ram_din/ram_we/ram_dout : the RAM's shared address port
// Ties between requesters are broken round-robin; a burst owns the RAM
// until its last word has come back.
module nn_ram_ctrl
  import nn_pkg::*;
#(
  parameter int unsigned bw     = 32,
  parameter int unsigned aw     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [aw-1:0] wr_addr,
  input  logic [bw-1:0] wr_data,
  input  logic          rd_valid_req,
  output logic          rd_ready_req,
  input  logic [aw-1:0] rd_base,
  input  logic [aw-1:0] rd_len,
  output logic          rd_busy,
  output logic [bw-1:0] rd_data,
  output logic          rd_dvalid,
  output logic          rd_last,
  output logic [aw-1:0] ram_addr,
  output logic [bw-1:0] ram_din,
  output logic          ram_we,
  input  logic [bw-1:0] ram_dout
);

  nn_ram_ctrl_state_t state_q, state_d;
  nn_grant_t          last_grant_q, last_grant_d;
  logic [aw-1:0]      ram_addr_q, ram_addr_d;
  logic [bw-1:0]      ram_din_q, ram_din_d;
  logic               ram_we_q, ram_we_d;
  logic [aw-1:0]      len_q, len_d;
  logic [aw-1:0]      cnt_q, cnt_d;

  logic wr_win, rd_win;
  logic issue_valid, issue_last;
  logic pipe_valid, pipe_last;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    wr_win = 1'b0;
    rd_win = 1'b0;
    if (state_q == IDLE && !Rst) begin
      wr_win = wr_valid & (~rd_valid_req | (last_grant_q == GRANT_RD));
      rd_win = rd_valid_req & (~wr_valid | (last_grant_q == GRANT_WR));
    end
  end

  assign wr_ready     = wr_win;
  assign rd_ready_req = rd_win;

  assign issue_valid = (state_q == RD_ISSUE);
  assign issue_last  = issue_valid && (cnt_q == len_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_we_d     = 1'b0;
    len_d        = len_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (wr_win) begin
          ram_we_d     = 1'b1;
          ram_addr_d   = wr_addr;
          ram_din_d    = wr_data;
          last_grant_d = GRANT_WR;
        end else if (rd_win) begin
          ram_addr_d   = rd_base;
          len_d        = rd_len;
          cnt_d        = '0;
          last_grant_d = GRANT_RD;
          state_d      = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (issue_last) begin
          state_d = (RD_LAT == 0) ? IDLE : RD_DRAIN;
        end else begin
          // Wraps naturally modulo 2**aw.
          ram_addr_d = ram_addr_q + aw'(1);
          cnt_d      = cnt_q + aw'(1);
        end
      end
      RD_DRAIN: begin
        if (pipe_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (Rst) begin
      state_d      = IDLE;
      // Reset as if the reader went last, so the writer wins the first tie.
      last_grant_d = GRANT_RD;
      ram_addr_d   = '0;
      ram_din_d    = '0;
      ram_we_d     = 1'b0;
      len_d        = '0;
      cnt_d        = '0;
    end
  end

  always_ff @(posedge Clk) begin
    state_q      <= state_d;
    last_grant_q <= last_grant_d;
    ram_addr_q   <= ram_addr_d;
    ram_din_q    <= ram_din_d;
    ram_we_q     <= ram_we_d;
    len_q        <= len_d;
    cnt_q        <= cnt_d;
  end

  nn_valid_pipe #(
    .Depth(RD_LAT)
  ) u_valid_pipe (
    .clk_i  (Clk),
    .clr_i  (Rst),
    .valid_i(issue_valid),
    .last_i (issue_last),
    .valid_o(pipe_valid),
    .last_o (pipe_last)
  );

  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign rd_busy   = (state_q != IDLE);
  assign rd_data   = ram_dout;
  assign rd_dvalid = pipe_valid;
  assign rd_last   = pipe_last;

endmodule

// File: tb/tb_nn_ram_ctrl.sv
// Scoreboard bench for nn_ram_ctrl with a registered (latency 1) RAM model.
// A cycle-level reference model predicts arbitration, then queues the RAM
// write, address and data beats expected for every accepted request.
module tb_nn_ram_ctrl;

  localparam int BW = 32;
  localparam int AW = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [BW-1:0] wr_data = '0;
  logic          rd_valid_req = 1'b0;
  logic          rd_ready_req;
  logic [AW-1:0] rd_base = '0;
  logic [AW-1:0] rd_len = '0;
  logic          rd_busy;
  logic [BW-1:0] rd_data;
  logic          rd_dvalid;
  logic          rd_last;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_din;
  logic          ram_we;
  logic [BW-1:0] ram_dout;

  nn_ram_ctrl #(
    .bw    (BW),
    .aw    (AW),
    .RD_LAT(RD_LAT)
  ) u_dut (
    .Clk         (clk),
    .Rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_valid_req(rd_valid_req),
    .rd_ready_req(rd_ready_req),
    .rd_base     (rd_base),
    .rd_len      (rd_len),
    .rd_busy     (rd_busy),
    .rd_data     (rd_data),
    .rd_dvalid   (rd_dvalid),
    .rd_last     (rd_last),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout)
  );

  always #5 clk = ~clk;

  // Attached RAM: registered read, one cycle latency.
  logic [BW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  exp_t wq[$];
  exp_t aq[$];
  exp_t dq[$];

  logic [BW-1:0] mdl_mem [DEPTH];
  bit  lg_rd = 1'b1;  // last grant went to reader; writer wins next tie
  int  free_cyc = 0;
  int  busy_lo = 1;
  int  busy_hi = 0;
  bit  prev_rst = 1'b0;
  bit  m_wr_fire = 1'b0;
  bit  m_rd_fire = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  int  n;
  bit  exp_we, exp_dv, idle, ew, er;
  exp_t e;

  // Monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    n = cyc;
    m_wr_fire = 1'b0;
    m_rd_fire = 1'b0;
    if (n >= 1) begin
      if (prev_rst) begin
        chk("rst_ram_we", 64'(ram_we), 64'(0));
        chk("rst_ram_addr", 64'(ram_addr), 64'(0));
        chk("rst_ram_din", 64'(ram_din), 64'(0));
        chk("rst_rd_dvalid", 64'(rd_dvalid), 64'(0));
        chk("rst_rd_last", 64'(rd_last), 64'(0));
        chk("rst_rd_busy", 64'(rd_busy), 64'(0));
      end

      exp_we = (wq.size() > 0) && (wq[0].cyc == n);
      chk("ram_we", 64'(ram_we), 64'(exp_we));
      if (exp_we) begin
        e = wq.pop_front();
        chk("wr_ram_addr", 64'(ram_addr), 64'(e.addr));
        chk("wr_ram_din", 64'(ram_din), 64'(e.data));
      end

      if ((aq.size() > 0) && (aq[0].cyc == n)) begin
        e = aq.pop_front();
        chk("rd_ram_addr", 64'(ram_addr), 64'(e.addr));
      end

      exp_dv = (dq.size() > 0) && (dq[0].cyc == n);
      chk("rd_dvalid", 64'(rd_dvalid), 64'(exp_dv));
      if (exp_dv) begin
        e = dq.pop_front();
        if (rd_dvalid) begin
          chk("rd_data", 64'(rd_data), 64'(e.data));
          chk("rd_last", 64'(rd_last), 64'(e.last));
        end
      end else begin
        chk("rd_last_idle", 64'(rd_last), 64'(0));
      end

      chk("rd_busy", 64'(rd_busy), 64'((n >= busy_lo) && (n <= busy_hi)));

      idle = !rst && (n >= free_cyc);
      ew = idle && wr_valid && (!rd_valid_req || lg_rd);
      er = idle && rd_valid_req && (!wr_valid || !lg_rd);
      chk("wr_ready", 64'(wr_ready), 64'(ew));
      chk("rd_ready_req", 64'(rd_ready_req), 64'(er));

      if (ew) begin
        wq.push_back('{cyc: n + 1, addr: wr_addr, data: wr_data, last: 1'b0});
        mdl_mem[wr_addr] = wr_data;
        lg_rd = 1'b0;
        m_wr_fire = 1'b1;
      end
      if (er) begin
        for (int k = 0; k <= int'(rd_len); k++) begin
          logic [AW-1:0] a;
          a = AW'(int'(rd_base) + k);
          aq.push_back('{cyc: n + 1 + k, addr: a, data: '0, last: 1'b0});
          dq.push_back('{cyc: n + 1 + k + RD_LAT, addr: a, data: mdl_mem[a],
                         last: (k == int'(rd_len))});
        end
        busy_lo = n + 1;
        busy_hi = n + 1 + int'(rd_len) + RD_LAT;
        free_cyc = n + 2 + int'(rd_len) + RD_LAT;
        lg_rd = 1'b1;
        m_rd_fire = 1'b1;
      end
      if (rst) begin
        wq.delete();
        aq.delete();
        dq.delete();
        if (busy_hi > n) busy_hi = n;
        free_cyc = n + 1;
        lg_rd = 1'b1;
      end
    end
    prev_rst = rst;
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
    int t = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!m_wr_fire && t < 1000);
    if (!m_wr_fire) chk("wr_handshake_timeout", 64'(0), 64'(1));
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] b, input logic [AW-1:0] l);
    int t = 0;
    rd_valid_req = 1'b1;
    rd_base      = b;
    rd_len       = l;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!m_rd_fire && t < 1000);
    if (!m_rd_fire) chk("rd_handshake_timeout", 64'(0), 64'(1));
    rd_valid_req = 1'b0;
  endtask

  task automatic step(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = $urandom;
      mdl_mem[i] = ram_mem[i];
    end
    step(3);
    rst = 1'b0;

    // Tie in the first IDLE after reset: writer first, reader next.
    fork
      do_write(8'd10, 32'h5A);
      do_read(8'd10, 8'd0);
    join
    step(4);

    // Write then burst read back.
    for (int i = 0; i < 4; i++) do_write(AW'(10 + i), BW'(32'hA0 + i));
    do_read(8'd10, 8'd3);
    step(6);

    // Second tie: reader went last, writer wins.
    fork
      do_write(8'd5, 32'hDEAD_BEEF);
      do_read(8'd5, 8'd1);
    join
    step(6);

    // Wrap-around burst.
    do_write(8'd254, 32'h1111_0254);
    do_write(8'd255, 32'h1111_0255);
    do_write(8'd0, 32'h1111_0000);
    do_write(8'd1, 32'h1111_0001);
    do_read(8'd254, 8'd3);
    step(6);

    // Write held off by a burst.
    fork
      do_read(8'd0, 8'd7);
      begin
        step(2);
        do_write(8'd33, 32'hC0FF_EE00);
      end
    join
    step(4);

    // Reset in the middle of a burst, then a write in the following IDLE.
    do_read(8'd40, 8'd7);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    do_write(8'd41, 32'h0BAD_F00D);
    step(3);

    // Full-RAM burst.
    do_read(8'd128, 8'd255);
    step(2);

    // Randomized mix.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: do_write(AW'($urandom), $urandom);
        1: do_read(AW'($urandom), AW'($urandom_range(0, 15)));
        default: begin
          fork
            do_write(AW'($urandom), $urandom);
            do_read(AW'($urandom), AW'($urandom_range(0, 15)));
          join
        end
      endcase
      step($urandom_range(0, 3));
    end

    begin
      int t = 0;
      while ((wq.size() + aq.size() + dq.size()) != 0 && t < 2000) begin
        step(1);
        t++;
      end
      chk("drain_empty", 64'(wq.size() + aq.size() + dq.size()), 64'(0));
    end
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
